// File: rtl/fpu_result_buffer.sv
// fpu_result_buffer: FIFO between the FP16 FPU output and its consumer, with sticky IEEE flags.
module fpu_result_buffer #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int TAG_WIDTH = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [WIDTH-1:0]           fpu_result_i,
    input  logic [4:0]                 fpu_status_i,
    input  logic [TAG_WIDTH-1:0]       fpu_tag_i,
    input  logic                       fpu_valid_i,
    output logic                       fpu_ready_o,
    output logic [WIDTH-1:0]           res_data_o,
    output logic [4:0]                 res_status_o,
    output logic [TAG_WIDTH-1:0]       res_tag_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    input  logic                       flush_i,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0]     mem_data   [DEPTH];
    logic [4:0]           mem_status [DEPTH];
    logic [TAG_WIDTH-1:0] mem_tag    [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 push, pop;

    // Ready looks only at registered count, so consumer ready never reaches the FPU.
    assign fpu_ready_o  = (count != CW'(DEPTH)) && !rst_i;
    assign res_valid_o  = count != '0;
    assign push         = fpu_valid_i && fpu_ready_o && !flush_i;
    assign pop          = res_valid_o && res_ready_i && !flush_i;
    assign res_data_o   = res_valid_o ? mem_data[rd_ptr]   : '0;
    assign res_status_o = res_valid_o ? mem_status[rd_ptr] : '0;
    assign res_tag_o    = res_valid_o ? mem_tag[rd_ptr]    : '0;
    assign count_o      = count;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr]   <= fpu_result_i;
            mem_status[wr_ptr] <= fpu_status_i;
            mem_tag[wr_ptr]    <= fpu_tag_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fflags_o <= '0;
        end else begin
            fflags_o <= (fflags_clr_i ? 5'd0 : fflags_o) | (pop ? res_status_o : 5'd0);
            if (flush_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
                rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
                count  <= count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
